// File: rtl/clint_pkg.sv
// Shared constants, bus bundles and helpers for the multi-hart CLINT.
// Offsets are byte addresses within the CLINT window.
package clint_pkg;

  localparam int unsigned MAX_HARTS     = 32;
  localparam int unsigned MSIP_BASE     = 32'h0000_0000;
  localparam int unsigned MTIMECMP_BASE = 32'h0000_4000;
  localparam int unsigned MTIME_OFFS    = 32'h0000_BFF8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } reg_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [63:0] rdata;
    logic        err;
  } reg_rsp_t;

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    return {{8{be[7]}}, {8{be[6]}}, {8{be[5]}}, {8{be[4]}},
            {8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// mtime tick source: synchronised RTC rising edge or
// a free-running PRESCALE down-counter.
module clint_tick_gen
  import clint_pkg::*;
#(
  parameter int unsigned USE_RTC     = 1,
  parameter int unsigned PRESCALE    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rtc_i,
  output logic tick_o
);

  localparam int unsigned CW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PRESCALE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rtc_tick, pre_tick;

  // shift RTC through synchroniser, edge-detect, count prescaler down
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], rtc_i};
    prev_d   = sync_q[SYNC_STAGES-1];
    rtc_tick = sync_q[SYNC_STAGES-1] & ~prev_q;
    pre_tick = (cnt_q == '0);
    cnt_d    = pre_tick ? RELOAD : cnt_q - 1'b1;
    tick_o   = (USE_RTC != 0) ? rtc_tick : pre_tick;
  end

  // tick-source state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= RELOAD;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/clint_multi_hart.sv
// Core-local interruptor for NR_HARTS harts: shared mtime,
// per-hart mtimecmp/msip, registered timer and software irqs.
module clint_multi_hart
  import clint_pkg::*;
#(
  parameter int unsigned NR_HARTS        = 4,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned USE_RTC         = 1,
  parameter int unsigned PRESCALE        = 16,
  parameter int unsigned RTC_SYNC_STAGES = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  rtc_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [63:0]           wdata_i,
  input  logic [7:0]            be_i,
  output logic                  rvalid_o,
  output logic [63:0]           rdata_o,
  output logic                  err_o,
  output logic [NR_HARTS-1:0]   timer_irq_o,
  output logic [NR_HARTS-1:0]   ipi_o
);

  localparam int unsigned MSIP_DW  = MSIP_BASE >> 3;
  localparam int unsigned CMP_DW   = MTIMECMP_BASE >> 3;
  localparam int unsigned MTIME_DW = MTIME_OFFS >> 3;

  logic                       unused_addr;
  logic [31:0]                dwi;
  logic [63:0]                wmask;
  logic                       tick;
  logic                       hit_mtime;
  logic                       mapped;
  logic [NR_HARTS-1:0]        hit_cmp, hit_msip;
  logic [NR_HARTS:0][63:0]    rd_acc;
  logic [63:0]                mtime_q, mtime_d;
  reg_rsp_t                   rsp_q, rsp_d;

  assign unused_addr = ^addr_i[2:0];
  assign dwi         = 32'(addr_i[ADDR_WIDTH-1:3]);
  assign wmask       = be_mask(be_i);
  assign hit_mtime   = req_i && (dwi == MTIME_DW);
  assign mapped      = hit_mtime | (|hit_cmp) | (|hit_msip);
  assign rd_acc[0]   = '0;

  clint_tick_gen #(
    .USE_RTC     (USE_RTC),
    .PRESCALE    (PRESCALE),
    .SYNC_STAGES (RTC_SYNC_STAGES)
  ) u_tick (
    .clk    (aclk),
    .rst_n  (aresetn),
    .rtc_i  (rtc_i),
    .tick_o (tick)
  );

  for (genvar g = 0; g < NR_HARTS; g++) begin : g_hart
    localparam int unsigned H   = g;
    localparam bit          ODD = (H % 2) == 1;

    logic [63:0] cmp_q, cmp_d, rd;
    logic        msip_q, msip_d, irq_q, irq_d;
    logic        msip_be, msip_wd;

    assign hit_cmp[g]  = req_i && (dwi == CMP_DW + H);
    assign hit_msip[g] = req_i && (dwi == MSIP_DW + H / 2);
    assign msip_be     = ODD ? be_i[4] : be_i[0];
    assign msip_wd     = ODD ? wdata_i[32] : wdata_i[0];

    // per-hart register update, compare and read contribution
    always_comb begin
      cmp_d = cmp_q;
      if (hit_cmp[g] && we_i)
        cmp_d = (cmp_q & ~wmask) | (wdata_i & wmask);
      msip_d = msip_q;
      if (hit_msip[g] && we_i && msip_be)
        msip_d = msip_wd;
      irq_d = (mtime_q >= cmp_q);
      rd = '0;
      if (hit_cmp[g])
        rd = cmp_q;
      if (hit_msip[g])
        rd = ODD ? {31'b0, msip_q, 32'b0} : {63'b0, msip_q};
    end

    // per-hart state
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        cmp_q  <= '1;
        msip_q <= 1'b0;
        irq_q  <= 1'b0;
      end else begin
        cmp_q  <= cmp_d;
        msip_q <= msip_d;
        irq_q  <= irq_d;
      end
    end

    assign rd_acc[g+1]    = rd_acc[g] | rd;
    assign timer_irq_o[g] = irq_q;
    assign ipi_o[g]       = msip_q;
  end

  // mtime: a bus write wins over a same-cycle tick
  always_comb begin
    mtime_d = mtime_q;
    if (hit_mtime && we_i)
      mtime_d = (mtime_q & ~wmask) | (wdata_i & wmask);
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  // response one cycle after request; writes return zero
  always_comb begin
    rsp_d.rvalid = req_i;
    rsp_d.err    = req_i & ~mapped;
    rsp_d.rdata  = '0;
    if (req_i && !we_i)
      rsp_d.rdata = rd_acc[NR_HARTS] |
                    (hit_mtime ? mtime_q : 64'd0);
  end

  // shared timer and response registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mtime_q <= '0;
      rsp_q   <= '0;
    end else begin
      mtime_q <= mtime_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rvalid_o = rsp_q.rvalid;
  assign rdata_o  = rsp_q.rdata;
  assign err_o    = rsp_q.err;

endmodule

// File: tb/tb_clint_multi_hart.sv
// Self-checking bench for clint_multi_hart (4 harts, prescaler
// tick every 4 cycles) with a response scoreboard.
module tb_clint_multi_hart;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        rtc_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic [7:0]  be_i = '0;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;
  logic [3:0]  timer_irq_o;
  logic [3:0]  ipi_o;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   edge_cnt = 0;

  clint_multi_hart #(
    .NR_HARTS(4), .ADDR_WIDTH(16), .USE_RTC(0),
    .PRESCALE(4), .RTC_SYNC_STAGES(2)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .rtc_i(rtc_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .timer_irq_o(timer_irq_o), .ipi_o(ipi_o)
  );

  always #5 aclk = ~aclk;

  // posedges since reset release; ticks land on multiples of 4
  always @(posedge aclk or negedge aresetn)
    if (!aresetn) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  // called at a negedge; request is sampled at the next posedge
  task automatic access(input logic we, input logic [15:0] a,
                        input logic [63:0] wd, input logic [7:0] be,
                        output logic v, output logic [63:0] rd,
                        output logic e);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
    @(negedge aclk);
    v = rvalid_o; rd = rdata_o; e = err_o;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0;
    wdata_i = '0; be_i = '0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    req_i = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // wait so the next access is sampled on an edge with index%4 == p
  task automatic align(input int p);
    while (((edge_cnt + 1) % 4) != p) @(negedge aclk);
  endtask

  task automatic test_reset();
    logic v, e;
    logic [63:0] rd;
    exp_t x;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    checks++;
    if (timer_irq_o !== 4'b0 || ipi_o !== 4'b0 || rvalid_o !== 1'b0)
      $display("FAIL reset_outputs: irq=%b ipi=%b rv=%b want 0",
               timer_irq_o, ipi_o, rvalid_o);
    else passes++;
    @(negedge aclk);
    aresetn = 1'b1;
    sb.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    access(1'b0, 16'h4000, '0, '0, v, rd, e);
    x = sb.pop_front();
    checks++;
    if (v !== 1'b1 || rd !== x.rdata || e !== x.err)
      $display("FAIL reset_cmp0: v=%b d=%h e=%b want v=1 d=%h e=%b",
               v, rd, e, x.rdata, x.err);
    else passes++;
  endtask

  task automatic test_mtime_count();
    logic v, e;
    logic [63:0] rd;
    exp_t x;
    do_reset();
    repeat (40) @(negedge aclk);
    sb.push_back('{64'd10, 1'b0});
    access(1'b0, 16'hBFF8, '0, '0, v, rd, e);
    x = sb.pop_front();
    checks++;
    if (v !== 1'b1 || rd !== x.rdata || e !== x.err)
      $display("FAIL mtime_40: v=%b d=%h e=%b want d=%h e=%b",
               v, rd, e, x.rdata, x.err);
    else passes++;
    sb.push_back('{64'd0, 1'b0});
    access(1'b1, 16'h4008, 64'd8, 8'hFF, v, rd, e);
    x = sb.pop_front();
    checks++;
    if (v !== 1'b1 || rd !== x.rdata || e !== x.err)
      $display("FAIL wr_cmp1: v=%b d=%h e=%b want d=%h e=%b",
               v, rd, e, x.rdata, x.err);
    else passes++;
    @(negedge aclk);
    checks++;
    if (timer_irq_o !== 4'b0010)
      $display("FAIL irq_cmp1: irq=%b want 0010", timer_irq_o);
    else passes++;
  endtask

  task automatic test_msip();
    logic v, e;
    logic [63:0] rd;
    exp_t x;
    logic        wr[6];
    logic [15:0] ad[6];
    logic [63:0] wd[6];
    logic [7:0]  bm[6];
    logic [3:0]  ipi_exp[6];
    logic [63:0] rd_exp[6];
    wr = '{1, 0, 1, 1, 1, 0};
    ad = '{16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0000, 16'h0000};
    wd = '{64'h1_0000_0000, 64'h0, 64'h1_0000_0001, 64'h0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    bm = '{8'hF0, 8'h00, 8'h0F, 8'hFF, 8'hFF, 8'h00};
    ipi_exp = '{4'b1000, 4'b1000, 4'b1100, 4'b0000, 4'b0011, 4'b0011};
    rd_exp = '{64'h0, 64'h1_0000_0000, 64'h0, 64'h0, 64'h0,
               64'h1_0000_0001};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rd_exp[i], 1'b0});
      access(wr[i], ad[i], wd[i], bm[i], v, rd, e);
      x = sb.pop_front();
      checks++;
      if (v !== 1'b1 || rd !== x.rdata || e !== x.err ||
          ipi_o !== ipi_exp[i])
        $display("FAIL msip_%0d: d=%h e=%b ipi=%b want d=%h e=%b ipi=%b",
                 i, rd, e, ipi_o, x.rdata, x.err, ipi_exp[i]);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    logic v, e;
    logic [63:0] rd;
    exp_t x;
    do_reset();
    access(1'b1, 16'h4000, 64'd5, 8'hFF, v, rd, e);
    align(1);
    sb.push_back('{64'd0, 1'b0});
    access(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, v, rd, e);
    x = sb.pop_front();
    checks++;
    if (v !== 1'b1 || rd !== x.rdata || e !== x.err)
      $display("FAIL wr_mtime_max: d=%h e=%b want d=%h e=%b",
               rd, e, x.rdata, x.err);
    else passes++;
    @(negedge aclk);
    checks++;
    if (timer_irq_o !== 4'b1111)
      $display("FAIL irq_at_max: irq=%b want 1111", timer_irq_o);
    else passes++;
    repeat (2) @(negedge aclk);
    sb.push_back('{64'd0, 1'b0});
    access(1'b0, 16'hBFF8, '0, '0, v, rd, e);
    x = sb.pop_front();
    checks++;
    if (v !== 1'b1 || rd !== x.rdata || e !== x.err)
      $display("FAIL mtime_wrap: d=%h e=%b want d=%h e=%b",
               rd, e, x.rdata, x.err);
    else passes++;
    checks++;
    if (timer_irq_o !== 4'b0000)
      $display("FAIL irq_after_wrap: irq=%b want 0000", timer_irq_o);
    else passes++;
  endtask

  task automatic test_write_vs_tick();
    logic v, e;
    logic [63:0] rd;
    exp_t x;
    align(1);
    access(1'b1, 16'hBFF8, 64'h0000_0007_0000_0100, 8'hFF, v, rd, e);
    align(0);
    access(1'b1, 16'hBFF8, 64'hDEAD_BEEF_0000_0200, 8'h0F, v, rd, e);
    sb.push_back('{64'h0000_0007_0000_0200, 1'b0});
    access(1'b0, 16'hBFF8, '0, '0, v, rd, e);
    x = sb.pop_front();
    checks++;
    if (v !== 1'b1 || rd !== x.rdata || e !== x.err)
      $display("FAIL write_vs_tick: d=%h want d=%h", rd, x.rdata);
    else passes++;
  endtask

  task automatic test_unmapped();
    logic v, e;
    logic [63:0] rd;
    exp_t x;
    logic        wr[6];
    logic [15:0] ad[6];
    logic [63:0] rd_exp[6];
    logic        er_exp[6];
    do_reset();
    wr = '{0, 0, 0, 1, 1, 0};
    ad = '{16'h4020, 16'h0010, 16'hBFF0, 16'h4020, 16'h0010, 16'h4004};
    rd_exp = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
               64'hFFFF_FFFF_FFFF_FFFF};
    er_exp = '{1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rd_exp[i], er_exp[i]});
      access(wr[i], ad[i], 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, v, rd, e);
      x = sb.pop_front();
      checks++;
      if (v !== 1'b1 || rd !== x.rdata || e !== x.err)
        $display("FAIL unmapped_%0d: d=%h e=%b want d=%h e=%b",
                 i, rd, e, x.rdata, x.err);
      else passes++;
    end
    sb.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    access(1'b0, 16'h4018, '0, '0, v, rd, e);
    x = sb.pop_front();
    checks++;
    if (rd !== x.rdata || e !== x.err || ipi_o !== 4'b0)
      $display("FAIL unmapped_nochg: d=%h e=%b ipi=%b want d=%h ipi=0",
               rd, e, ipi_o, x.rdata);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic v, e;
    logic [63:0] rd;
    exp_t x;
    logic        wr[3];
    logic [63:0] wd[3];
    logic [7:0]  bm[3];
    logic [63:0] rd_exp[3];
    wr = '{1, 1, 0};
    wd = '{64'h1111_2222_3333_4444, 64'h0000_0000_AAAA_0000, 64'h0};
    bm = '{8'hFF, 8'h0C, 8'h00};
    rd_exp = '{64'h0, 64'h0, 64'h1111_2222_AAAA_4444};
    for (int i = 0; i < 3; i++)
      sb.push_back('{rd_exp[i], 1'b0});
    for (int i = 0; i < 3; i++) begin
      access(wr[i], 16'h4010, wd[i], bm[i], v, rd, e);
      x = sb.pop_front();
      checks++;
      if (v !== 1'b1 || rd !== x.rdata || e !== x.err)
        $display("FAIL b2b_%0d: d=%h e=%b want d=%h e=%b",
                 i, rd, e, x.rdata, x.err);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_access();
    req_i = 1'b1; we_i = 1'b1; addr_i = 16'h0000;
    wdata_i = 64'h1; be_i = 8'h01;
    @(negedge aclk);
    req_i = 1'b0; we_i = 1'b0; wdata_i = '0; be_i = '0;
    checks++;
    if (rvalid_o !== 1'b1 || ipi_o[0] !== 1'b1)
      $display("FAIL mid_pre: rv=%b ipi=%b want rv=1 ipi0=1",
               rvalid_o, ipi_o);
    else passes++;
    aresetn = 1'b0;
    #1;
    checks++;
    if (rvalid_o !== 1'b0 || ipi_o !== 4'b0 || timer_irq_o !== 4'b0)
      $display("FAIL mid_reset: rv=%b ipi=%b irq=%b want 0",
               rvalid_o, ipi_o, timer_irq_o);
    else passes++;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (rvalid_o !== 1'b0 || sb.size() != 0)
      $display("FAIL mid_after: rv=%b sb=%0d want 0 0",
               rvalid_o, sb.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_mtime_count();
    test_msip();
    test_wrap();
    test_write_vs_tick();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
